// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: per-cycle hold/bubble decode,
// data-miss and halt sequencing, and saturating stall/redirect counters.
module pipe_hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             mem_dmemREN,
   input  logic             mem_dmemWEN,
   input  logic             mem_halt,
   input  logic             ex_memread,
   input  logic [4:0]       ex_rt,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             ex_redirect,
   output logic             pc_en,
   output logic             pc_redirect,
   output logic             ifid_dopause,
   output logic             ifid_flush,
   output logic             idex_dopause,
   output logic             idex_flush,
   output logic             exmem_dopause,
   output logic             exmem_flush,
   output logic             memwb_dopause,
   output logic             memwb_flush,
   output logic             halt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {RUN, DWAIT, HALTED} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t state, next_state;
   logic   halt_q;
   logic   dwait, lu, miss;
   logic   stall_inc, flush_inc;

   assign dwait = (mem_dmemREN | mem_dmemWEN) & ~dhit;
   assign lu    = ex_memread & (ex_rt != 5'd0) & ((ex_rt == id_rs) | (ex_rt == id_rt));
   // Once waiting, only dhit releases the miss; the access request is not re-sampled.
   assign miss  = (state == DWAIT) ? ~dhit : dwait;

   always_comb begin
      pc_en         = 1'b1;
      pc_redirect   = 1'b0;
      ifid_dopause  = 1'b0;
      ifid_flush    = 1'b0;
      idex_dopause  = 1'b0;
      idex_flush    = 1'b0;
      exmem_dopause = 1'b0;
      exmem_flush   = 1'b0;
      memwb_dopause = 1'b0;
      memwb_flush   = 1'b0;
      flush_inc     = 1'b0;
      next_state    = state;

      if (RST) begin
         pc_en       = 1'b0;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
         memwb_flush = 1'b1;
      end else if (state == HALTED) begin
         pc_en         = 1'b0;
         ifid_dopause  = 1'b1;
         idex_dopause  = 1'b1;
         exmem_dopause = 1'b1;
         memwb_dopause = 1'b1;
      end else if (miss) begin
         pc_en         = 1'b0;
         ifid_dopause  = 1'b1;
         idex_dopause  = 1'b1;
         exmem_dopause = 1'b1;
         memwb_flush   = 1'b1;
         next_state    = DWAIT;
      end else begin
         next_state = RUN;
         if (mem_halt) begin
            next_state = HALTED;
         end else if (lu) begin
            pc_en        = 1'b0;
            ifid_dopause = 1'b1;
            idex_flush   = 1'b1;
         end else if (ex_redirect && ihit) begin
            pc_redirect = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            flush_inc   = 1'b1;
         end else if (ex_redirect) begin
            // Branch stays parked in EX so the redirect is re-presented next cycle.
            pc_en        = 1'b0;
            ifid_dopause = 1'b1;
            idex_dopause = 1'b1;
            exmem_flush  = 1'b1;
         end else if (!ihit) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
         end
      end
   end

   assign stall_inc = ~pc_en & (state != HALTED);
   assign halt      = halt_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= RUN;
         halt_q    <= 1'b0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state <= next_state;
         if (state != HALTED && next_state == HALTED)
            halt_q <= 1'b1;
         if (stall_inc && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_ONE;
         if (flush_inc && flush_cnt != '1)
            flush_cnt <= flush_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table plus randomized run against a
// rule-level reference model; a 4-bit counter instance checks saturation.
module tb_pipe_hazard_ctrl;

   typedef struct packed {
      logic       ihit, dhit, ren, wen, mh, mr;
      logic [4:0] ex_rt, rs, rt;
      logic       redir;
   } in_t;

   // {pc_en, pc_redirect, ifid_p, ifid_f, idex_p, idex_f, exmem_p, exmem_f, memwb_p, memwb_f}
   typedef logic [9:0] ctl_t;

   typedef struct {
      in_t  in;
      bit   rst;
      ctl_t ctl;
      bit   h;
      int   stall;
      int   flush;
   } row_t;

   localparam ctl_t C_RST   = 10'b00_01_01_01_01;
   localparam ctl_t C_DEF   = 10'b10_00_00_00_00;
   localparam ctl_t C_MISS  = 10'b00_10_10_10_01;
   localparam ctl_t C_LU    = 10'b00_10_01_00_00;
   localparam ctl_t C_RED   = 10'b11_01_01_00_00;
   localparam ctl_t C_RHOLD = 10'b00_10_10_01_00;
   localparam ctl_t C_IMISS = 10'b00_01_00_00_00;
   localparam ctl_t C_HALT  = 10'b00_10_10_10_10;

   typedef enum int {R_RST, R_HALTED, R_MISS, R_HACC, R_LU, R_RED, R_RHOLD, R_IMISS, R_DEF} rule_t;

   logic CLK, RST;
   logic ihit, dhit, ren, wen, mh, mr, redir;
   logic [4:0] ex_rt, rs, rt;

   logic pc_en, pc_redirect, ifid_p, ifid_f, idex_p, idex_f, exmem_p, exmem_f, memwb_p, memwb_f, halt;
   logic [15:0] stall16, flush16;
   logic pc_en4, pc_redirect4, ifid_p4, ifid_f4, idex_p4, idex_f4, exmem_p4, exmem_f4, memwb_p4, memwb_f4, halt4;
   logic [3:0] stall4, flush4;

   ctl_t ctl_act;
   assign ctl_act = {pc_en, pc_redirect, ifid_p, ifid_f, idex_p, idex_f, exmem_p, exmem_f, memwb_p, memwb_f};

   pipe_hazard_ctrl dut (
      .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_dmemREN(ren), .mem_dmemWEN(wen),
      .mem_halt(mh), .ex_memread(mr), .ex_rt(ex_rt), .id_rs(rs), .id_rt(rt), .ex_redirect(redir),
      .pc_en(pc_en), .pc_redirect(pc_redirect), .ifid_dopause(ifid_p), .ifid_flush(ifid_f),
      .idex_dopause(idex_p), .idex_flush(idex_f), .exmem_dopause(exmem_p), .exmem_flush(exmem_f),
      .memwb_dopause(memwb_p), .memwb_flush(memwb_f), .halt(halt),
      .stall_cnt(stall16), .flush_cnt(flush16)
   );

   pipe_hazard_ctrl #(.CNT_W(4)) dut4 (
      .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_dmemREN(ren), .mem_dmemWEN(wen),
      .mem_halt(mh), .ex_memread(mr), .ex_rt(ex_rt), .id_rs(rs), .id_rt(rt), .ex_redirect(redir),
      .pc_en(pc_en4), .pc_redirect(pc_redirect4), .ifid_dopause(ifid_p4), .ifid_flush(ifid_f4),
      .idex_dopause(idex_p4), .idex_flush(idex_f4), .exmem_dopause(exmem_p4), .exmem_flush(exmem_f4),
      .memwb_dopause(memwb_p4), .memwb_flush(memwb_f4), .halt(halt4),
      .stall_cnt(stall4), .flush_cnt(flush4)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int   n_vec = 0;
   int   n_bad = 0;
   bit   m_halted, m_waiting;
   int   m_stall, m_flush;
   rule_t m_rule;
   ctl_t e_ctl;
   row_t tbl[$];

   function automatic in_t mk(bit ih, bit dh, bit rn, bit wn, bit hl, bit lr,
                              int xr, int s, int t, bit rd);
      in_t x;
      x.ihit = ih; x.dhit = dh; x.ren = rn; x.wen = wn; x.mh = hl; x.mr = lr;
      x.ex_rt = 5'(xr); x.rs = 5'(s); x.rt = 5'(t); x.redir = rd;
      return x;
   endfunction

   function automatic row_t mkrow(in_t i, bit r, ctl_t c, bit h, int s, int f);
      row_t x;
      x.in = i; x.rst = r; x.ctl = c; x.h = h; x.stall = s; x.flush = f;
      return x;
   endfunction

   function automatic int sat(int v, int w);
      int top;
      top = (1 << w) - 1;
      return (v > top) ? top : v;
   endfunction

   // Reference: pick the highest-priority rule that applies, then look up its output pattern.
   task automatic model_eval(input in_t i, input bit r);
      bit miss, lu;
      if (r) begin
         m_halted = 0; m_waiting = 0; m_stall = 0; m_flush = 0;
      end
      miss = m_waiting ? !i.dhit : ((i.ren | i.wen) & !i.dhit);
      lu   = i.mr && (i.ex_rt != 0) && (i.ex_rt == i.rs || i.ex_rt == i.rt);
      if (r)                       m_rule = R_RST;
      else if (m_halted)           m_rule = R_HALTED;
      else if (miss)               m_rule = R_MISS;
      else if (i.mh)               m_rule = R_HACC;
      else if (lu)                 m_rule = R_LU;
      else if (i.redir && i.ihit)  m_rule = R_RED;
      else if (i.redir)            m_rule = R_RHOLD;
      else if (!i.ihit)            m_rule = R_IMISS;
      else                         m_rule = R_DEF;
      case (m_rule)
         R_RST:    e_ctl = C_RST;
         R_HALTED: e_ctl = C_HALT;
         R_MISS:   e_ctl = C_MISS;
         R_LU:     e_ctl = C_LU;
         R_RED:    e_ctl = C_RED;
         R_RHOLD:  e_ctl = C_RHOLD;
         R_IMISS:  e_ctl = C_IMISS;
         default:  e_ctl = C_DEF;
      endcase
   endtask

   task automatic model_commit();
      if (m_rule == R_RST) return;
      if (m_rule != R_HALTED && !e_ctl[9]) m_stall++;
      if (m_rule == R_RED) m_flush++;
      m_waiting = (m_rule == R_MISS);
      if (m_rule == R_HACC) m_halted = 1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic applyStimulus(input in_t i, input bit r, input bit use_row, input row_t row);
      ihit = i.ihit; dhit = i.dhit; ren = i.ren; wen = i.wen; mh = i.mh; mr = i.mr;
      ex_rt = i.ex_rt; rs = i.rs; rt = i.rt; redir = i.redir; RST = r;
      model_eval(i, r);
      @(negedge CLK);
      if (use_row) begin
         checkOutput("ctl",   32'(ctl_act), 32'(row.ctl));
         checkOutput("halt",  32'(halt),    32'(row.h));
         checkOutput("stall", 32'(stall16), 32'(row.stall));
         checkOutput("flush", 32'(flush16), 32'(row.flush));
      end else begin
         checkOutput("rnd_ctl",   32'(ctl_act), 32'(e_ctl));
         checkOutput("rnd_halt",  32'(halt),    32'(m_halted));
         checkOutput("rnd_stall", 32'(stall16), 32'(sat(m_stall, 16)));
         checkOutput("rnd_flush", 32'(flush16), 32'(sat(m_flush, 16)));
      end
      checkOutput("stall4", 32'(stall4), 32'(sat(m_stall, 4)));
      checkOutput("flush4", 32'(flush4), 32'(sat(m_flush, 4)));
      @(posedge CLK);
      model_commit();
      #1;
   endtask

   initial begin
      in_t  idle, junk, x;
      row_t dummy;
      idle  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      junk  = mk(0, 0, 1, 0, 1, 1, 2, 2, 2, 1);
      dummy = mkrow(idle, 0, C_DEF, 0, 0, 0);
      RST = 1'b1;

      // Reset, idle run, load-use incl. r0 and priority over redirect
      tbl.push_back(mkrow(idle, 1, C_RST, 0, 0, 0));
      for (int k = 0; k < 10; k++) tbl.push_back(mkrow(idle, 0, C_DEF, 0, 0, 0));
      tbl.push_back(mkrow(mk(1,0,0,0,0,1,5,5,0,0), 0, C_LU,  0, 0, 0));
      tbl.push_back(mkrow(mk(1,0,0,0,0,1,0,0,0,0), 0, C_DEF, 0, 1, 0));
      tbl.push_back(mkrow(mk(1,0,0,0,0,1,7,1,7,0), 0, C_LU,  0, 1, 0));
      tbl.push_back(mkrow(mk(1,0,0,0,0,1,3,3,0,1), 0, C_LU,  0, 2, 0));
      // Data miss for 3 cycles (ihit ignored while waiting), release on dhit
      tbl.push_back(mkrow(mk(1,0,1,0,0,0,0,0,0,0), 0, C_MISS, 0, 3, 0));
      tbl.push_back(mkrow(mk(1,0,1,0,0,0,0,0,0,0), 0, C_MISS, 0, 4, 0));
      tbl.push_back(mkrow(mk(0,0,1,0,0,0,0,0,0,0), 0, C_MISS, 0, 5, 0));
      tbl.push_back(mkrow(mk(1,1,1,0,0,0,0,0,0,0), 0, C_DEF,  0, 6, 0));
      // Redirect held on icache miss, then accepted
      tbl.push_back(mkrow(mk(0,0,0,0,0,0,0,0,0,1), 0, C_RHOLD, 0, 6, 0));
      tbl.push_back(mkrow(mk(0,0,0,0,0,0,0,0,0,1), 0, C_RHOLD, 0, 7, 0));
      tbl.push_back(mkrow(mk(1,0,0,0,0,0,0,0,0,1), 0, C_RED,   0, 8, 0));
      tbl.push_back(mkrow(idle,                    0, C_DEF,   0, 8, 1));
      tbl.push_back(mkrow(mk(0,0,0,0,0,0,0,0,0,0), 0, C_IMISS, 0, 8, 1));
      // Redirect frozen under a store miss, serviced on release
      tbl.push_back(mkrow(mk(1,0,0,1,0,0,0,0,0,1), 0, C_MISS, 0, 9, 1));
      tbl.push_back(mkrow(mk(1,1,0,1,0,0,0,0,0,1), 0, C_RED,  0, 10, 1));
      tbl.push_back(mkrow(idle,                    0, C_DEF,  0, 10, 2));
      // Halt behind a miss, then frozen in HALTED until reset
      tbl.push_back(mkrow(mk(1,0,1,0,1,0,0,0,0,0), 0, C_MISS, 0, 10, 2));
      tbl.push_back(mkrow(mk(1,1,1,0,1,0,0,0,0,0), 0, C_DEF,  0, 11, 2));
      for (int k = 0; k < 5; k++) tbl.push_back(mkrow(junk, 0, C_HALT, 1, 11, 2));
      tbl.push_back(mkrow(idle, 1, C_RST, 0, 0, 0));
      tbl.push_back(mkrow(idle, 0, C_DEF, 0, 0, 0));
      // Long icache miss run saturates the 4-bit instance
      for (int k = 0; k < 20; k++) tbl.push_back(mkrow(mk(0,0,0,0,0,0,0,0,0,0), 0, C_IMISS, 0, k, 0));
      tbl.push_back(mkrow(idle, 0, C_DEF, 0, 20, 0));
      // Reset in the middle of DWAIT drops back to RUN
      tbl.push_back(mkrow(mk(1,0,1,0,0,0,0,0,0,0), 0, C_MISS, 0, 20, 0));
      tbl.push_back(mkrow(mk(1,0,1,0,0,0,0,0,0,0), 0, C_MISS, 0, 21, 0));
      tbl.push_back(mkrow(mk(1,0,1,0,0,0,0,0,0,0), 1, C_RST,  0, 0, 0));
      tbl.push_back(mkrow(idle,                    0, C_DEF,  0, 0, 0));

      foreach (tbl[k]) applyStimulus(tbl[k].in, tbl[k].rst, 1'b1, tbl[k]);

      for (int k = 0; k < 400; k++) begin
         x.ihit  = ($urandom_range(0, 3) != 0);
         x.dhit  = ($urandom_range(0, 2) != 0);
         x.ren   = ($urandom_range(0, 3) == 0);
         x.wen   = ($urandom_range(0, 5) == 0);
         x.mh    = ($urandom_range(0, 29) == 0);
         x.mr    = ($urandom_range(0, 2) == 0);
         x.ex_rt = 5'($urandom_range(0, 3));
         x.rs    = 5'($urandom_range(0, 3));
         x.rt    = 5'($urandom_range(0, 3));
         x.redir = ($urandom_range(0, 4) == 0);
         applyStimulus(x, ($urandom_range(0, 49) == 0), 1'b0, dummy);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Each cycle, decides PC enable and redirect select, and hold (dopause) or bubble (flush) for each latch: IF/ID, ID/EX, EX/MEM, MEM/WB.
- Inputs: cache hits, load-use and branch resolution info, and the halt flag.
- Holds a small FSM for data-miss and halt sequencing, plus saturating performance counters.
- Sits beside the datapath. Its dopause outputs drive the latches' ifid_ip_dopause/idex_ip_dopause-style inputs.

Parameters:
CNT_W, 16, width of stall_cnt and flush_cnt

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-high reset
ihit  in  1  icache hit for current PC
dhit  in  1  dcache hit for MEM-stage access
mem_dmemREN  in  1  MEM stage issues load
mem_dmemWEN  in  1  MEM stage issues store
mem_halt  in  1  halt instruction in MEM stage
ex_memread  in  1  ID/EX holds a load
ex_rt  in  5  destination reg of that load
id_rs  in  5  IF/ID source register rs
id_rt  in  5  IF/ID source register rt
ex_redirect  in  1  branch taken / jump resolved in EX
pc_en  out  1  PC register load enable
pc_redirect  out  1  PC mux selects EX target
ifid_dopause  out  1  hold IF/ID
ifid_flush  out  1  load bubble into IF/ID
idex_dopause  out  1  hold ID/EX
idex_flush  out  1  load bubble into ID/EX
exmem_dopause  out  1  hold EX/MEM
exmem_flush  out  1  load bubble into EX/MEM
memwb_dopause  out  1  hold MEM/WB
memwb_flush  out  1  load bubble into MEM/WB
halt  out  1  sticky, processor halted
stall_cnt  out  CNT_W  cycles with pc_en=0 outside HALTED, saturating
flush_cnt  out  CNT_W  accepted redirects, saturating

Behaviour:
Decode rules:
- Control outputs are combinational from state and inputs. FSM and counters are registered.
- Default (no condition): pc_en=1, all dopause=0, all flush=0, pc_redirect=0.
- dwait = (mem_dmemREN | mem_dmemWEN) & !dhit.
- lu = ex_memread & ex_rt!=0 & (ex_rt==id_rs | ex_rt==id_rt).

While RST is high:
- pc_en=0, all four flush=1, all dopause=0, halt=0.
- State=RUN, counters=0.

States: RUN, DWAIT, HALTED.

RUN — conditions are priority encoded, first match wins:
1. dwait: pc_en=0; ifid/idex/exmem dopause=1; memwb_flush=1; next=DWAIT.
2. mem_halt: default outputs this cycle (the halt advances into MEM/WB); next=HALTED.
3. lu: pc_en=0; ifid_dopause=1; idex_flush=1. The redirect is ignored this cycle; lu and ex_redirect cannot legally coexist. Bench checks the priority only.
4. ex_redirect & ihit: pc_redirect=1, pc_en=1; ifid_flush=1; idex_flush=1; flush_cnt+1.
5. ex_redirect & !ihit: pc_en=0; ifid_dopause=1; idex_dopause=1; exmem_flush=1. This holds the branch in EX so the redirect re-presents next cycle.
6. !ihit: pc_en=0; ifid_flush=1; downstream advances.

DWAIT:
- Same outputs as RUN rule 1 while !dhit.
- On dhit: release this cycle. Outputs are evaluated by RUN rules 2–6 with the dwait term false; next=RUN.
- A redirect or lu pending during DWAIT is frozen and serviced on release.
- ihit is ignored in DWAIT.

HALTED:
- pc_en=0, all dopause=1, all flush=0, halt=1.
- Only RST leaves HALTED.

halt register: set on the RUN→HALTED transition; visible the cycle after mem_halt is accepted.

Counters:
- stall_cnt increments on every cycle with pc_en=0 in RUN or DWAIT; it saturates at all-ones.
- flush_cnt increments only on rule 4.
- Both are frozen in HALTED.

Asynchronous reset mid-DWAIT or mid-stall: immediately returns to the reset decode; no pending state survives.

Test Plan:
1. Reset, then ihit=1, no hazards, 10 cycles → pc_en=1 every cycle, all dopause/flush=0, stall_cnt=0.
2. Load-use: ex_memread=1, ex_rt=5, id_rs=5 for 1 cycle → pc_en=0, ifid_dopause=1, idex_flush=1; stall_cnt=1. Repeat with ex_rt=0 → no stall.
3. dmemREN=1, dhit=0 for 3 cycles then dhit=1 → DWAIT for 3 cycles: exmem_dopause=1, memwb_flush=1. Release on the 4th cycle; stall_cnt=3.
4. ex_redirect with ihit=0 for 2 cycles, then ihit=1 → 2 cycles of hold plus exmem_flush. Then pc_redirect=1, ifid_flush=1, idex_flush=1; flush_cnt=1.
5. mem_halt=1 with dhit=0 → DWAIT first. On dhit, go to HALTED; halt=1 next cycle; all dopause=1; counters frozen for 20 cycles. RST clears halt.
6. Force stall_cnt near all-ones (CNT_W=4 build) with ihit=0 for 20 cycles → stall_cnt stays 15. Assert RST mid-DWAIT → outputs immediately take the reset decode; state=RUN after release.
